// File: rtl/dcache_pkg.sv
// Shared types and helpers for the D-cache data-array controller.
package dcache_pkg;

    localparam int SETS  = 32;
    localparam int IDXW  = 5;
    localparam int LINEW = 128;
    localparam int BEATS = 4;
    localparam int CNTW  = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    // Active-low byte mask for a 32-bit word store into a 128-bit line.
    function automatic logic [15:0] bweb_for(input logic [1:0] word, input logic [3:0] strb);
        logic [15:0] m;
        m = '1;
        m[4*word +: 4] = ~strb;
        return m;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU bit store: one combinational read port, two update ports.
// The hi port (refill line write) overrides the lo port (core access) on a
// same-set collision.
module dcache_lru
    import dcache_pkg::*;
(
    input  logic            CK,
    input  logic            rstn,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_val,
    input  logic            hi_en,
    input  logic [IDXW-1:0] hi_idx,
    input  logic            hi_val,
    input  logic            lo_en,
    input  logic [IDXW-1:0] lo_idx,
    input  logic            lo_val
);

    logic [SETS-1:0] lru;

    assign rd_val = lru[rd_idx];

    // Later assignment wins, so the hi port takes priority.
    always_ff @(posedge CK or negedge rstn) begin
        if (!rstn) begin
            lru <= '0;
        end else begin
            if (lo_en) lru[lo_idx] <= lo_val;
            if (hi_en) lru[hi_idx] <= hi_val;
        end
    end

endmodule

// File: rtl/dcache_data_ctrl.sv
// D-cache data-array sequencer: arbitrates core word accesses against
// 4-beat refills, assembles the refill line and tracks LRU victims.
module dcache_data_ctrl
    import dcache_pkg::*;
(
    input  logic             CK,
    input  logic             rstn,
    input  logic             core_req,
    output logic             core_gnt,
    input  logic             core_we,
    input  logic             core_way,
    input  logic [IDXW-1:0]  core_idx,
    input  logic [1:0]       core_word,
    input  logic [31:0]      core_wdata,
    input  logic [3:0]       core_wstrb,
    output logic             core_rvalid,
    output logic [31:0]      core_rdata,
    input  logic             fill_start,
    input  logic [IDXW-1:0]  fill_idx,
    output logic             fill_way,
    input  logic             fill_bvalid,
    input  logic [31:0]      fill_bdata,
    output logic             fill_busy,
    output logic             fill_done,
    output logic             CS,
    output logic [1:0]       OE,
    output logic [1:0]       WEB,
    output logic [15:0]      BWEB,
    output logic [IDXW-1:0]  A,
    output logic [LINEW-1:0] DI,
    input  logic [LINEW-1:0] DO
);

    state_t            state, state_nxt;
    logic [IDXW-1:0]   fidx_q;
    logic [LINEW-1:0]  line_q;
    logic [CNTW-1:0]   cnt_q;
    logic [1:0]        word_q;
    logic              lru_rd;
    logic              fill_accept;
    logic              beat_accept;

    // Line write always wins; same-set core accesses wait out the whole refill.
    assign core_gnt  = core_req & (state != WRITE) &
                       ~((state == COLLECT) & (core_idx == fidx_q));
    assign fill_busy = (state != IDLE);
    assign fill_accept = (state == IDLE) & fill_start;
    assign beat_accept = (state == COLLECT) & fill_bvalid;

    // Read data arrives the cycle after the read edge; word_q picks the slice.
    assign core_rdata = core_rvalid ? DO[32*word_q +: 32] : '0;

    // State register.
    always_ff @(posedge CK or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and array-port drive (refill write or granted core access).
    always_comb begin
        state_nxt = state;
        CS        = 1'b0;
        WEB       = 2'b11;
        BWEB      = '1;
        A         = '0;
        DI        = '0;
        fill_done = 1'b0;
        case (state)
            IDLE:    if (fill_start) state_nxt = COLLECT;
            COLLECT: if (fill_bvalid && cnt_q == CNTW'(BEATS-1)) state_nxt = WRITE;
            WRITE: begin
                state_nxt     = IDLE;
                CS            = 1'b1;
                A             = fidx_q;
                WEB[fill_way] = 1'b0;
                BWEB          = '0;
                DI            = line_q;
                fill_done     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // core_gnt is never high in WRITE, so the two drives never overlap.
        if (core_gnt) begin
            CS = 1'b1;
            A  = core_idx;
            if (core_we) begin
                WEB[core_way] = 1'b0;
                BWEB          = bweb_for(core_word, core_wstrb);
                DI            = {4{core_wdata}};
            end
        end
    end

    // Refill bookkeeping, beat assembly, and the registered read-side state.
    always_ff @(posedge CK or negedge rstn) begin
        if (!rstn) begin
            fidx_q      <= '0;
            fill_way    <= 1'b0;
            line_q      <= '0;
            cnt_q       <= '0;
            OE          <= 2'b01;
            word_q      <= '0;
            core_rvalid <= 1'b0;
        end else begin
            if (fill_accept) begin
                fidx_q   <= fill_idx;
                fill_way <= lru_rd;
                cnt_q    <= '0;
            end
            if (beat_accept) begin
                line_q[32*cnt_q +: 32] <= fill_bdata;
                cnt_q                  <= cnt_q + 1'b1;
            end
            core_rvalid <= core_gnt & ~core_we;
            if (core_gnt & ~core_we) begin
                OE     <= core_way ? 2'b10 : 2'b01;
                word_q <= core_word;
            end
        end
    end

    dcache_lru u_lru (
        .CK     (CK),
        .rstn   (rstn),
        .rd_idx (fill_idx),
        .rd_val (lru_rd),
        .hi_en  (state == WRITE),
        .hi_idx (fidx_q),
        .hi_val (~fill_way),
        .lo_en  (core_gnt),
        .lo_idx (core_idx),
        .lo_val (~core_way)
    );

endmodule
